// File: rtl/debug_dma_cmdq_pkg.sv
// Shared types for the debug DMA command sequencer: request/command formats,
// FSM state encoding and field widths.
package debug_dma_cmdq_pkg;

  localparam int NTHREAD      = 8;
  localparam int NTHREADIDMSB = 2;
  localparam int CMDQ_LENW    = 12;
  localparam int CMDQ_BUFAW   = 8;
  localparam int CMDQ_CNTW    = 8;
  localparam bit LUTRAMPROT   = 1'b1;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef enum logic [1:0] {
    dma_NOP   = 2'd0,
    dma_READ  = 2'd1,
    dma_WRITE = 2'd2
  } dma_cmd_type;

  typedef enum logic [1:0] {
    CMDQ_IDLE  = 2'd0,
    CMDQ_ISSUE = 2'd1,
    CMDQ_WAIT  = 2'd2
  } cmdq_state_type;

  typedef struct packed {
    logic [NTHREADIDMSB:0]  tid;
    logic [31:0]            addr;
    logic [CMDQ_BUFAW-1:0]  buf_addr;
    logic [CMDQ_LENW-1:0]   len;
    dma_cmd_type            cmd;
  } debug_dma_cmdq_req_type;

  typedef struct packed {
    logic [31:0] addr;
    logic        par;
  } debug_dma_addr_reg_type;

  typedef struct packed {
    logic [CMDQ_BUFAW-1:0] buf_addr;
    logic [CMDQ_CNTW-1:0]  count;
    dma_cmd_type           cmd;
    logic                  last;
    logic                  par;
  } debug_dma_ctrl_reg_type;

  typedef struct packed {
    logic [NTHREADIDMSB:0]  tid;
    logic                   addr_we;
    logic                   ctrl_we;
    debug_dma_addr_reg_type addr_reg;
    debug_dma_ctrl_reg_type ctrl_reg;
  } debug_dma_cmdif_in_type;

endpackage

// File: rtl/debug_dma_cmdq_fifo.sv
// Per-channel request FIFO: distributed RAM with extra-bit wrap pointers.
// The full flag is registered from next-state pointers so the producer sees it one cycle after the filling push.
module debug_dma_cmdq_fifo
  import debug_dma_cmdq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  debug_dma_cmdq_req_type din,
  output debug_dma_cmdq_req_type dout,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  debug_dma_cmdq_req_type mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        full_q, full_d;

  always_comb begin
    wr_d   = wr_q + (AW+1)'(push);
    rd_d   = rd_q + (AW+1)'(pop);
    full_d = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = full_q;

endmodule

// File: rtl/debug_dma_cmdq.sv
// Round-robin command sequencer in front of debug_dma: queues per-channel requests,
// splits them into MAXBURST chunks and tracks per-thread busy/completion from done.
//
// state      | meaning
// CMDQ_IDLE  | arbitrate channel heads whose tid is not busy; load working regs
// CMDQ_ISSUE | addr/ctrl write enables held until dma_cmd_ack
// CMDQ_WAIT  | chunk in flight; wait for done on the working tid
module debug_dma_cmdq
  import debug_dma_cmdq_pkg::*;
#(
  parameter int NCHAN    = 2,
  parameter int DEPTH    = 4,
  parameter int MAXBURST = 64,
  parameter bit PARITY   = LUTRAMPROT
) (
  input  iu_clk_type             gclk,
  input  logic                   rst,
  input  logic [NCHAN-1:0]       req_valid,
  output logic [NCHAN-1:0]       req_ready,
  input  debug_dma_cmdq_req_type req_data [NCHAN],
  output debug_dma_cmdif_in_type dma_cmd_in,
  input  logic                   dma_cmd_ack,
  input  logic                   done_valid,
  input  logic [NTHREADIDMSB:0]  done_tid,
  output logic [NTHREAD-1:0]     busy,
  output logic                   cmpl_valid,
  output logic [NTHREADIDMSB:0]  cmpl_tid,
  output logic                   err
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CMDQ_LENW-1:0] MAXB = CMDQ_LENW'(MAXBURST);

  logic clk;
  assign clk = gclk.clk;

  logic [NCHAN-1:0]       fifo_full, fifo_empty, fifo_push, fifo_pop;
  debug_dma_cmdq_req_type head [NCHAN];

  cmdq_state_type         state_q, state_d;
  logic [NTHREADIDMSB:0]  tid_q, tid_d;
  logic [31:0]            addr_q, addr_d;
  logic [CMDQ_BUFAW-1:0]  buf_q, buf_d;
  logic [CMDQ_LENW-1:0]   rem_q, rem_d;
  dma_cmd_type            cmd_q, cmd_d;
  logic [CW-1:0]          chan_q, chan_d, rr_q, rr_d;
  logic [NTHREAD-1:0]     busy_q, busy_d, last_q, last_d;
  logic                   cmpl_valid_q, cmpl_valid_d, err_q, err_d, init_q;
  logic [NTHREADIDMSB:0]  cmpl_tid_q, cmpl_tid_d;

  logic                   grant_vld;
  logic [CW-1:0]          grant_ch;
  logic [CMDQ_LENW-1:0]   chunk, rem_left;
  logic                   is_last;

  assign fifo_push = req_valid & req_ready;

  for (genvar c = 0; c < NCHAN; c++) begin : g_fifo
    debug_dma_cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[c]),
      .pop   (fifo_pop[c]),
      .din   (req_data[c]),
      .dout  (head[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // Search starts at rr_q; uses registered busy only, so a done never feeds straight into a grant.
  always_comb begin
    logic [CW:0]   sum;
    logic [CW-1:0] idx;
    grant_vld = 1'b0;
    grant_ch  = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NCHAN; i++) begin
      sum = {1'b0, rr_q} + (CW+1)'(i);
      if (sum >= (CW+1)'(NCHAN)) sum = sum - (CW+1)'(NCHAN);
      idx = sum[CW-1:0];
      if (!grant_vld && !fifo_empty[idx] && !busy_q[head[idx].tid]) begin
        grant_vld = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  assign chunk    = (rem_q > MAXB) ? MAXB : rem_q;
  assign is_last  = (rem_q <= MAXB);
  assign rem_left = rem_q - chunk;

  always_comb begin
    state_d      = state_q;
    tid_d        = tid_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    rem_d        = rem_q;
    cmd_d        = cmd_q;
    chan_d       = chan_q;
    rr_d         = rr_q;
    busy_d       = busy_q;
    last_d       = last_q;
    err_d        = err_q;
    cmpl_valid_d = 1'b0;
    cmpl_tid_d   = cmpl_tid_q;
    fifo_pop     = '0;
    dma_cmd_in   = '0;

    if (done_valid) begin
      busy_d[done_tid] = 1'b0;
      last_d[done_tid] = 1'b0;
      if (!busy_q[done_tid]) begin
        err_d = 1'b1;
      end else if (last_q[done_tid]) begin
        cmpl_valid_d = 1'b1;
        cmpl_tid_d   = done_tid;
      end
    end

    case (state_q)
      CMDQ_IDLE: begin
        if (grant_vld) begin
          rr_d = (grant_ch == CW'(NCHAN-1)) ? '0 : grant_ch + 1'b1;
          if (head[grant_ch].len == '0) begin
            fifo_pop[grant_ch] = 1'b1;
            err_d              = 1'b1;
          end else begin
            tid_d   = head[grant_ch].tid;
            addr_d  = head[grant_ch].addr;
            buf_d   = head[grant_ch].buf_addr;
            rem_d   = head[grant_ch].len;
            cmd_d   = head[grant_ch].cmd;
            chan_d  = grant_ch;
            state_d = CMDQ_ISSUE;
          end
        end
      end
      CMDQ_ISSUE: begin
        dma_cmd_in.tid               = tid_q;
        dma_cmd_in.addr_we           = 1'b1;
        dma_cmd_in.ctrl_we           = 1'b1;
        dma_cmd_in.addr_reg.addr     = addr_q;
        dma_cmd_in.addr_reg.par      = PARITY & (^addr_q);
        dma_cmd_in.ctrl_reg.buf_addr = buf_q;
        dma_cmd_in.ctrl_reg.count    = CMDQ_CNTW'(chunk);
        dma_cmd_in.ctrl_reg.cmd      = cmd_q;
        dma_cmd_in.ctrl_reg.last     = is_last;
        dma_cmd_in.ctrl_reg.par      = PARITY & (^{buf_q, CMDQ_CNTW'(chunk), cmd_q, is_last});
        if (dma_cmd_ack) begin
          busy_d[tid_q] = 1'b1;
          last_d[tid_q] = is_last;
          rem_d         = rem_left;
          addr_d        = addr_q + 32'(chunk);
          buf_d         = buf_q + chunk[CMDQ_BUFAW-1:0];
          if (rem_left == '0) begin
            fifo_pop[chan_q] = 1'b1;
            state_d          = CMDQ_IDLE;
          end else begin
            state_d = CMDQ_WAIT;
          end
        end
      end
      CMDQ_WAIT: begin
        if (done_valid && (done_tid == tid_q)) state_d = CMDQ_ISSUE;
      end
      default: state_d = CMDQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CMDQ_IDLE;
      tid_q        <= '0;
      addr_q       <= '0;
      buf_q        <= '0;
      rem_q        <= '0;
      cmd_q        <= dma_NOP;
      chan_q       <= '0;
      rr_q         <= '0;
      busy_q       <= '0;
      last_q       <= '0;
      err_q        <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_tid_q   <= '0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tid_q        <= tid_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      rem_q        <= rem_d;
      cmd_q        <= cmd_d;
      chan_q       <= chan_d;
      rr_q         <= rr_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
      err_q        <= err_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_tid_q   <= cmpl_tid_d;
      init_q       <= 1'b1;
    end
  end

  assign req_ready  = {NCHAN{init_q}} & ~fifo_full;
  assign busy       = busy_q;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_tid   = cmpl_tid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_debug_dma_cmdq.sv
// Directed bench for debug_dma_cmdq: NCHAN=2, DEPTH=4, MAXBURST=64, parity on.
// Stimulus is driven and outputs checked one time unit after the falling edge.
module tb_debug_dma_cmdq;
  import debug_dma_cmdq_pkg::*;

  localparam int NCHAN = 2;

  logic                   clk = 1'b0;
  iu_clk_type             gclk;
  logic                   rst;
  logic [NCHAN-1:0]       req_valid;
  logic [NCHAN-1:0]       req_ready;
  debug_dma_cmdq_req_type req_data [NCHAN];
  debug_dma_cmdif_in_type dma_cmd_in;
  logic                   dma_cmd_ack;
  logic                   done_valid;
  logic [2:0]             done_tid;
  logic [7:0]             busy;
  logic                   cmpl_valid;
  logic [2:0]             cmpl_tid;
  logic                   err;
  logic                   ack_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          nwr   = 0;
  int          ncmpl = 0;
  logic [31:0] w_addr [64];
  logic [7:0]  w_cnt  [64];
  logic [7:0]  w_buf  [64];
  logic        w_last [64];
  logic [2:0]  w_tid  [64];
  logic        w_apar [64];
  logic        w_cpar [64];
  int          w_cyc  [64];

  assign gclk.clk = clk;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dma_cmd_ack = ack_en & dma_cmd_in.addr_we;

  debug_dma_cmdq #(.NCHAN(NCHAN), .DEPTH(4), .MAXBURST(64), .PARITY(1'b1)) dut (
    .gclk        (gclk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .dma_cmd_in  (dma_cmd_in),
    .dma_cmd_ack (dma_cmd_ack),
    .done_valid  (done_valid),
    .done_tid    (done_tid),
    .busy        (busy),
    .cmpl_valid  (cmpl_valid),
    .cmpl_tid    (cmpl_tid),
    .err         (err)
  );

  always @(negedge clk) begin
    if (dma_cmd_in.addr_we && dma_cmd_ack && nwr < 64) begin
      w_addr[nwr] <= dma_cmd_in.addr_reg.addr;
      w_cnt[nwr]  <= dma_cmd_in.ctrl_reg.count;
      w_buf[nwr]  <= dma_cmd_in.ctrl_reg.buf_addr;
      w_last[nwr] <= dma_cmd_in.ctrl_reg.last;
      w_tid[nwr]  <= dma_cmd_in.tid;
      w_apar[nwr] <= dma_cmd_in.addr_reg.par;
      w_cpar[nwr] <= dma_cmd_in.ctrl_reg.par;
      w_cyc[nwr]  <= cyc;
      nwr         <= nwr + 1;
    end
    if (cmpl_valid) ncmpl <= ncmpl + 1;
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push(input bit c, input logic [2:0] t, input logic [31:0] a,
                      input logic [7:0] b, input logic [11:0] l, output int pcyc);
    @(negedge clk); #1;
    req_data[c]  = '{tid: t, addr: a, buf_addr: b, len: l, cmd: dma_WRITE};
    req_valid[c] = 1'b1;
    pcyc         = cyc;
    @(negedge clk); #1;
    req_valid[c] = 1'b0;
  endtask

  task automatic push2(input logic [2:0] t0, input logic [31:0] a0,
                       input logic [2:0] t1, input logic [31:0] a1);
    @(negedge clk); #1;
    req_data[0] = '{tid: t0, addr: a0, buf_addr: 8'h00, len: 12'd4, cmd: dma_READ};
    req_data[1] = '{tid: t1, addr: a1, buf_addr: 8'h00, len: 12'd4, cmd: dma_READ};
    req_valid   = 2'b11;
    @(negedge clk); #1;
    req_valid   = 2'b00;
  endtask

  task automatic done(input logic [2:0] t);
    @(negedge clk); #1;
    done_valid = 1'b1;
    done_tid   = t;
    @(negedge clk); #1;
    done_valid = 1'b0;
  endtask

  task automatic wait_wr(input int n, output bit ok);
    int k;
    k = 0;
    while (nwr < n && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (nwr >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; done_valid = 1'b0; done_tid = '0; ack_en = 1'b1;
    for (int i = 0; i < NCHAN; i++) req_data[i] = '0;
    step(2);
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got=%b exp=00", req_ready); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy: got=%h exp=00", busy); end
    total++; if (dma_cmd_in !== '0) begin bad++; $display("FAIL reset_cmd: got=%h exp=0", dma_cmd_in); end
    total++; if (cmpl_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags: cmpl=%b err=%b exp 0 0", cmpl_valid, err); end
    rst = 1'b1;
    step(1);
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL ready_after_reset: got=%b exp=11", req_ready); end
  endtask

  task automatic test_single();
    int  p, n0;
    bit  ok;
    logic exp_cpar;
    n0 = nwr;
    push(1'b0, 3'd3, 32'h1000, 8'h10, 12'd10, p);
    wait_wr(n0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: writes=%0d exp=%0d", nwr, n0 + 1); end
    total++; if (w_cyc[n0] - p !== 2) begin bad++; $display("FAIL single_latency: got=%0d exp=2", w_cyc[n0] - p); end
    total++; if (w_addr[n0] !== 32'h1000 || w_cnt[n0] !== 8'd10 || w_last[n0] !== 1'b1 || w_tid[n0] !== 3'd3 || w_buf[n0] !== 8'h10)
      begin bad++; $display("FAIL single_fields: addr=%h cnt=%0d last=%b tid=%0d buf=%h exp 1000 10 1 3 10", w_addr[n0], w_cnt[n0], w_last[n0], w_tid[n0], w_buf[n0]); end
    exp_cpar = ^{8'h10, 8'd10, 2'b10, 1'b1};
    total++; if (w_apar[n0] !== 1'b1 || w_cpar[n0] !== exp_cpar) begin bad++; $display("FAIL single_parity: apar=%b cpar=%b exp 1 %b", w_apar[n0], w_cpar[n0], exp_cpar); end
    step(1);
    total++; if (busy !== 8'b0000_1000) begin bad++; $display("FAIL single_busy: got=%b exp=00001000", busy); end
    done(3'd3);
    total++; if (cmpl_valid !== 1'b1 || cmpl_tid !== 3'd3) begin bad++; $display("FAIL single_cmpl: valid=%b tid=%0d exp 1 3", cmpl_valid, cmpl_tid); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL single_busy_clr: got=%b exp=0", busy); end
  endtask

  task automatic test_hold();
    int  p, n0, k;
    bit  ok;
    n0 = nwr;
    ack_en = 1'b0;
    push(1'b0, 3'd3, 32'h2000, 8'h00, 12'd5, p);
    k = 0;
    while (!dma_cmd_in.addr_we && k < 20) begin step(1); k++; end
    total++; if (dma_cmd_in.addr_we !== 1'b1) begin bad++; $display("FAIL hold_we_timeout: we=%b exp=1", dma_cmd_in.addr_we); end
    step(3);
    total++; if (dma_cmd_in.addr_we !== 1'b1 || dma_cmd_in.ctrl_we !== 1'b1 || dma_cmd_in.addr_reg.addr !== 32'h2000 || dma_cmd_in.ctrl_reg.count !== 8'd5)
      begin bad++; $display("FAIL hold_stable: we=%b%b addr=%h cnt=%0d exp 11 2000 5", dma_cmd_in.addr_we, dma_cmd_in.ctrl_we, dma_cmd_in.addr_reg.addr, dma_cmd_in.ctrl_reg.count); end
    @(posedge clk); #1;
    ack_en = 1'b1;
    wait_wr(n0 + 1, ok);
    total++; if (!ok || nwr !== n0 + 1) begin bad++; $display("FAIL hold_single_write: writes=%0d exp=%0d", nwr - n0, 1); end
    done(3'd3);
  endtask

  task automatic test_burst_split();
    logic [31:0] ea [3];
    logic [7:0]  ec [3];
    logic [7:0]  eb [3];
    logic        el [3];
    int  p, n0, c0;
    bit  ok;
    ea = '{32'h1000, 32'h1040, 32'h1080};
    ec = '{8'd64, 8'd64, 8'd22};
    eb = '{8'h00, 8'h40, 8'h80};
    el = '{1'b0, 1'b0, 1'b1};
    n0 = nwr;
    c0 = ncmpl;
    push(1'b0, 3'd2, 32'h1000, 8'h00, 12'd150, p);
    for (int k = 0; k < 3; k++) begin
      wait_wr(n0 + k + 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL burst_timeout%0d: writes=%0d exp=%0d", k, nwr - n0, k + 1); end
      total++; if (w_addr[n0+k] !== ea[k] || w_cnt[n0+k] !== ec[k] || w_buf[n0+k] !== eb[k] || w_last[n0+k] !== el[k])
        begin bad++; $display("FAIL burst_chunk%0d: addr=%h cnt=%0d buf=%h last=%b exp %h %0d %h %b", k, w_addr[n0+k], w_cnt[n0+k], w_buf[n0+k], w_last[n0+k], ea[k], ec[k], eb[k], el[k]); end
      step(3);
      total++; if (nwr !== n0 + k + 1) begin bad++; $display("FAIL burst_early_issue%0d: writes=%0d exp=%0d", k, nwr - n0, k + 1); end
      done(3'd2);
      total++; if (cmpl_valid !== el[k]) begin bad++; $display("FAIL burst_cmpl%0d: got=%b exp=%b", k, cmpl_valid, el[k]); end
    end
    total++; if (ncmpl - c0 !== 1 || cmpl_tid !== 3'd2) begin bad++; $display("FAIL burst_cmpl_count: n=%0d tid=%0d exp 1 2", ncmpl - c0, cmpl_tid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] et [4];
    int  n0;
    bit  ok;
    // Earlier grants all went to ch0, so the pointer now sits on ch1.
    et = '{3'd4, 3'd0, 3'd6, 3'd1};
    n0 = nwr;
    push2(3'd0, 32'h8000, 3'd4, 32'h8100);
    push2(3'd1, 32'h8010, 3'd6, 32'h8110);
    wait_wr(n0 + 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout: writes=%0d exp=4", nwr - n0); end
    for (int k = 0; k < 4; k++) begin
      total++; if (w_tid[n0+k] !== et[k]) begin bad++; $display("FAIL rr_order%0d: tid=%0d exp=%0d", k, w_tid[n0+k], et[k]); end
    end
    for (int k = 0; k < 4; k++) done(et[k]);
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL rr_busy_clr: got=%b exp=0", busy); end
  endtask

  task automatic test_fifo_full();
    int  p, n0, n1;
    bit  ok;
    logic [31:0] ea;
    n0 = nwr;
    push(1'b1, 3'd7, 32'h3000, 8'h00, 12'd4, p);
    wait_wr(n0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_block_timeout: writes=%0d exp=1", nwr - n0); end
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 3'd7, 32'h4000 + 32'(16 * k), 8'h00, 12'd4, p);
      total++; if (req_ready[0] !== (k < 3)) begin bad++; $display("FAIL full_ready%0d: got=%b exp=%b", k, req_ready[0], (k < 3)); end
    end
    push(1'b0, 3'd7, 32'h5000, 8'h00, 12'd4, p);
    n1 = nwr;
    done(3'd7);
    wait_wr(n1 + 1, ok);
    step(1);
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got=%b exp=1", req_ready[0]); end
    for (int k = 1; k < 4; k++) begin
      done(3'd7);
      wait_wr(n1 + k + 1, ok);
    end
    done(3'd7);
    step(10);
    total++; if (nwr !== n1 + 4) begin bad++; $display("FAIL full_drain_count: writes=%0d exp=4", nwr - n1); end
    for (int k = 0; k < 4; k++) begin
      ea = 32'h4000 + 32'(16 * k);
      total++; if (w_addr[n1+k] !== ea) begin bad++; $display("FAIL full_drain_addr%0d: got=%h exp=%h", k, w_addr[n1+k], ea); end
    end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL full_busy_clr: got=%b exp=0", busy); end
  endtask

  task automatic test_zero_len();
    int  p, n0;
    bit  ok;
    n0 = nwr;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_err_before: got=%b exp=0", err); end
    push(1'b0, 3'd0, 32'h6100, 8'h00, 12'd0, p);
    step(5);
    total++; if (nwr !== n0 || err !== 1'b1) begin bad++; $display("FAIL zero_popped: writes=%0d err=%b exp 0 1", nwr - n0, err); end
    push(1'b0, 3'd0, 32'h6000, 8'h00, 12'd1, p);
    wait_wr(n0 + 1, ok);
    total++; if (!ok || w_addr[n0] !== 32'h6000 || w_cnt[n0] !== 8'd1) begin bad++; $display("FAIL zero_next_head: addr=%h cnt=%0d exp 6000 1", w_addr[n0], w_cnt[n0]); end
    done(3'd0);
  endtask

  task automatic test_reset_mid();
    int  p, n0;
    bit  ok;
    n0 = nwr;
    push(1'b0, 3'd1, 32'h7000, 8'h00, 12'd150, p);
    wait_wr(n0 + 1, ok);
    push(1'b1, 3'd2, 32'h7800, 8'h00, 12'd4, p);
    step(2);
    total++; if (!ok || nwr !== n0 + 1 || busy !== 8'b0000_0010) begin bad++; $display("FAIL mid_wait_state: writes=%0d busy=%b exp 1 00000010", nwr - n0, busy); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 8'h00 || dma_cmd_in !== '0 || err !== 1'b0 || cmpl_valid !== 1'b0 || req_ready !== 2'b00)
      begin bad++; $display("FAIL mid_reset_vals: busy=%b cmd=%h err=%b cmpl=%b rdy=%b exp all 0", busy, dma_cmd_in, err, cmpl_valid, req_ready); end
    step(1);
    rst = 1'b1;
    step(20);
    total++; if (nwr !== n0 + 1 || req_ready !== 2'b11 || busy !== 8'h00) begin bad++; $display("FAIL mid_after_release: writes=%0d rdy=%b busy=%b exp 1 11 0", nwr - n0, req_ready, busy); end
  endtask

  task automatic test_err_done();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL errdone_before: got=%b exp=0", err); end
    done(3'd5);
    total++; if (err !== 1'b1 || cmpl_valid !== 1'b0) begin bad++; $display("FAIL errdone_set: err=%b cmpl=%b exp 1 0", err, cmpl_valid); end
    step(10);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL errdone_sticky: got=%b exp=1", err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_burst_split();
    test_round_robin();
    test_fifo_full();
    test_zero_len();
    test_reset_mid();
    test_err_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
